// File: rtl/rtc_pkg.sv
// Shared definitions for the rtc real-time clock: field limits, field width,
// the time-of-day struct and a binary-to-packed-BCD helper.
package rtc_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned FIELD_W = 8;

    typedef struct packed {
        logic [FIELD_W-1:0] hours;
        logic [FIELD_W-1:0] minutes;
        logic [FIELD_W-1:0] seconds;
    } rtc_time_t;

    // Packs a value 0..99 as two BCD digits: tens in [7:4], units in [3:0].
    function automatic logic [FIELD_W-1:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// One time-of-day field: a modulo-(MAX+1) counter that counts either in plain
// binary or directly in packed BCD digits (BCD=1). tc_o flags value == MAX so
// the parent can chain the carry into the next field.
module rtc_mod_counter
    import rtc_pkg::*;
#(
    parameter int unsigned MAX = 59,
    parameter bit          BCD = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    output logic [FIELD_W-1:0] value_o,
    output logic               tc_o
);

    // Terminal value in the same encoding as the register.
    localparam logic [FIELD_W-1:0] MAX_ENC = BCD ? to_bcd(MAX) : FIELD_W'(MAX);

    // NOTE: the declaration initializer gives the power-up value of 0 so the
    // outputs read zero before the first reset edge; reset still clears it.
    logic [FIELD_W-1:0] value_q = '0;
    logic [FIELD_W-1:0] value_d;
    logic               illegal;

    assign value_o = value_q;
    assign tc_o    = (value_q == MAX_ENC);

    // Flag values outside the field's range (including a BCD units digit above 9).
    // With valid digits, packed BCD orders the same as the number it encodes.
    always_comb begin
        illegal = (value_q > MAX_ENC) || (BCD && (value_q[3:0] > 4'd9));
    end

    // Next-state: recover from illegal values, wrap at MAX, otherwise count.
    always_comb begin
        value_d = value_q;
        if (illegal) begin
            value_d = '0;
        end else if (enable_i) begin
            if (tc_o) begin
                value_d = '0;
            end else if (BCD && (value_q[3:0] == 4'd9)) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = value_q + 8'd1;
            end
        end
    end

    // Field register; synchronous reset wins over counting.
    // NOTE: sequential state uses non-blocking assignments so every field
    // samples the pre-edge values and the cascade updates in one edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/rtc.sv
// Free-running 24-hour time-of-day clock advanced by each rising edge of a
// 1 Hz clock. Fields are registered; encoding is plain binary by default and
// packed BCD when the macro RTC_BCD_EN is defined.
module rtc
    import rtc_pkg::*;
(
    input  logic               clk_1s,
    input  logic               reset,
    output logic [FIELD_W-1:0] seconds,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] hours
);

`ifdef RTC_BCD_EN
    localparam bit BCD_SEL = 1'b1;
`else
    localparam bit BCD_SEL = 1'b0;
`endif

    rtc_time_t now;
    logic      sec_en;
    logic      min_en;
    logic      hr_en;
    logic      sec_tc;
    logic      min_tc;
    logic      hr_tc_unused;   // day-wrap flag; nothing downstream consumes it

    // Carry chain: each field advances only when every lower field wraps.
    assign sec_en = 1'b1;
    assign min_en = sec_tc & sec_en;
    assign hr_en  = min_tc & min_en;

    rtc_mod_counter #(.MAX(SEC_MAX), .BCD(BCD_SEL)) u_sec (
        .clk_i    (clk_1s),
        .reset_i  (reset),
        .enable_i (sec_en),
        .value_o  (now.seconds),
        .tc_o     (sec_tc)
    );

    rtc_mod_counter #(.MAX(MIN_MAX), .BCD(BCD_SEL)) u_min (
        .clk_i    (clk_1s),
        .reset_i  (reset),
        .enable_i (min_en),
        .value_o  (now.minutes),
        .tc_o     (min_tc)
    );

    rtc_mod_counter #(.MAX(HR_MAX), .BCD(BCD_SEL)) u_hr (
        .clk_i    (clk_1s),
        .reset_i  (reset),
        .enable_i (hr_en),
        .value_o  (now.hours),
        .tc_o     (hr_tc_unused)
    );

    assign seconds = now.seconds;
    assign minutes = now.minutes;
    assign hours   = now.hours;

endmodule

// File: tb/tb_rtc.sv
// Self-checking bench for rtc. A reference model keeps elapsed seconds since
// the last reset (mod 86400) and derives h/m/s arithmetically; every edge is
// compared, plus explicit boundary points. Define RTC_BCD_EN for the BCD build.
module tb_rtc;

    logic       clk_1s;
    logic       reset;
    logic [7:0] seconds;
    logic [7:0] minutes;
    logic [7:0] hours;

    int vectors;
    int miscompares;
    int t_model;    // elapsed seconds since the last reset edge, mod 86400

    rtc dut (
        .clk_1s  (clk_1s),
        .reset   (reset),
        .seconds (seconds),
        .minutes (minutes),
        .hours   (hours)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    function automatic logic [7:0] enc(input int v);
`ifdef RTC_BCD_EN
        return 8'((v / 10) * 16 + (v % 10));
`else
        return 8'(v);
`endif
    endfunction

    function automatic logic [23:0] enc3(input int h, input int m, input int s);
        return {enc(h), enc(m), enc(s)};
    endfunction

    function automatic logic [23:0] model_time(input int t);
        return enc3(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    function automatic logic [23:0] observed();
        return {hours, minutes, seconds};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed h/m/s=%h expected h/m/s=%h (t=%0d)", tag, obs, exp, t_model);
        end
    endtask

    // Apply one clock edge with the given reset level, advance the model and compare.
    task automatic step(input logic rst);
        reset = rst;
        @(posedge clk_1s);
        #1;
        if (rst) t_model = 0;
        else     t_model = (t_model + 1) % 86400;
        check("edge", observed(), model_time(t_model));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t_model     = 0;
        reset       = 1'b0;

        // Power-up value before any edge.
        #1;
        check("powerup", observed(), 24'h000000);

        // Random run with sporadic resets, then reset from wherever it landed.
        begin
            int n;
            n = $urandom_range(800, 200);
            for (int i = 0; i < n; i++) begin
                step($urandom_range(63, 0) == 0);
            end
        end
        step(1'b1);
        check("reset_one", observed(), 24'h000000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("reset_hold", observed(), 24'h000000);
        end

        // Seconds rollover, minute carry, then reset in the middle of the hour carry.
        for (int i = 1; i <= 3599; i++) begin
            step(1'b0);
            if (i == 1)    check("first_after_reset", observed(), enc3(0, 0, 1));
            if (i == 59)   check("sec_59", observed(), enc3(0, 0, 59));
            if (i == 60)   check("min_carry", observed(), enc3(0, 1, 0));
            if (i == 3599) check("hr_minus1", observed(), enc3(0, 59, 59));
        end
        step(1'b1);
        check("reset_mid_carry", observed(), 24'h000000);
        step(1'b0);
        check("release", observed(), enc3(0, 0, 1));

        // Full day from zero.
        step(1'b1);
        for (int i = 1; i <= 86399; i++) begin
            step(1'b0);
            if (i == 3600)  check("hr_carry", observed(), enc3(1, 0, 0));
            if (i == 43200) check("noon", observed(), enc3(12, 0, 0));
            if (i == 86399) begin
`ifdef RTC_BCD_EN
                check("day_end", observed(), 24'h235959);
`else
                check("day_end", observed(), 24'h173B3B);
`endif
            end
        end
        step(1'b0);
        check("day_wrap", observed(), 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
